multi_level_checker: RTL
========================

// Module: multi_level_checker
// PURPOSE
//  Receive-side scoreboard for the 3-stage multi-level flop/AND pipeline: observes the stimulus
//  driven into the pipeline and the pipeline's output, models the expected result, and compares
//  them cycle by cycle. Reports per-cycle mismatches, a sticky error flag, saturating pass/fail
//  counts and the last failing pair. Sits beside the pipeline on the same clk domain.
// PARAMETERS
//  WIDTH        3   lanes of stim / dut_out
//  LATENCY      2   clk edges from stim sample to matching dut_out sample (>=1)
//  CNT_W        8   width of err_count and pass_count
//  STOP_ON_ERR  0   1: enter HALT on first mismatch; 0: keep checking
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  en          in   1        stim valid this cycle; push an expectation
//  clear       in   1        synchronous clear of counters, flags, model; FSM -> IDLE
//  stim        in   WIDTH    value driven into pipeline input this cycle
//  dut_out     in   WIDTH    pipeline output
//  checking    out  1        state is CHECK
//  mismatch    out  1        one-cycle pulse: last comparison failed
//  err_flag    out  1        sticky: any mismatch since reset/clear
//  halted      out  1        state is HALT
//  err_count   out  CNT_W    failed comparisons, saturating at all-ones
//  pass_count  out  CNT_W    passed comparisons, saturating at all-ones
//  last_exp    out  WIDTH    expected value of the most recent mismatch
//  last_got    out  WIDTH    dut_out value of the most recent mismatch
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, model cleared, FSM IDLE.
//  Model: each edge, push {valid=en, exp={WIDTH{&stim}}} into a LATENCY-deep shift line.
//   The head entry is the one pushed LATENCY edges earlier. With en=1 on edge t, dut_out is
//   compared at edge t+LATENCY.
//  Compare (each edge, head.valid=1, state PRIME or CHECK):
//   - dut_out==head.exp: pass_count++ (saturating).
//   - otherwise: mismatch<=1, err_flag<=1, err_count++ (saturating), last_exp<=head.exp,
//     last_got<=dut_out.
//   - mismatch is 0 on every edge without a failed compare.
//   - Head entries with valid=0 are not compared.
//  FSM:
//   - IDLE -> PRIME on en=1.
//   - PRIME -> CHECK when the head entry is valid; the compare occurs on that same edge.
//   - CHECK -> IDLE when en=0 and all LATENCY entries are invalid (drained).
//   - PRIME/CHECK -> HALT on a failed compare when STOP_ON_ERR=1. The failing compare is
//     still recorded.
//   - HALT: no pushes, no compares, counters frozen; leave only via clear or reset.
//  en gaps in CHECK: bubbles propagate as invalid entries; the state stays CHECK until drained.
//  clear (priority over all other events that edge):
//   - counters, err_flag, mismatch, last_* <= 0; all entries invalid; FSM -> IDLE.
//   - The stim presented that cycle is discarded.
//  Saturation: at all-ones a counter holds. err_flag and last_* still update.
//  Reset mid-run: immediate return to reset values; no partial compare completes.
// TESTING
//  1 stim=3'b111 en=1 for 4 cycles, dut_out correct -> first compare at edge 2;
//    pass_count=4, err_flag=0, checking=1 then drops once en=0 and drained.
//  2 stim=3'b110 then 3'b111, dut_out forced 3'b000 on 2nd compare -> mismatch pulse 1 cycle,
//    err_count=1, last_exp=3'b111, last_got=3'b000, err_flag sticky.
//  3 STOP_ON_ERR=1, inject error on 3rd compare -> halted=1, err_count=1, pass_count=2;
//    later stim ignored; clear -> all 0, IDLE.
//  4 en pattern 1,0,1 with correct dut_out -> pass_count=2; the bubble is not counted.
//  5 CNT_W=2, 5 errors -> err_count holds 3, last_* tracks the 5th error.
//  6 rst_n low mid-CHECK -> all outputs 0 immediately; after release, IDLE until en=1.

Source files
------------

// File: rtl/multi_level_checker_if.sv
// rtl/multi_level_checker_if.sv - stimulus/observation bundle between pipeline harness and checker
interface multi_level_checker_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] stim;
  logic [WIDTH-1:0] dut_out;
  logic             checking;
  logic             mismatch;
  logic             err_flag;
  logic             halted;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] pass_count;
  logic [WIDTH-1:0] last_exp;
  logic [WIDTH-1:0] last_got;

  modport master (
    output en, clear, stim, dut_out,
    input  checking, mismatch, err_flag, halted, err_count, pass_count, last_exp, last_got
  );

  modport slave (
    input  en, clear, stim, dut_out,
    output checking, mismatch, err_flag, halted, err_count, pass_count, last_exp, last_got
  );
endinterface

// File: rtl/multi_level_checker.sv
// rtl/multi_level_checker.sv - scoreboard for the 3-stage flop/AND pipeline
module multi_level_checker #(
  parameter int WIDTH       = 3,
  parameter int LATENCY     = 2,
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_level_checker_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PRIME, CHECK, HALT} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]   exp_q [LATENCY];
  logic [WIDTH-1:0]   exp_d [LATENCY];
  logic               mismatch_q, mismatch_d;
  logic               err_flag_q, err_flag_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [WIDTH-1:0]   last_exp_q, last_exp_d;
  logic [WIDTH-1:0]   last_got_q, last_got_d;
  logic               do_cmp;
  logic               cmp_fail;

  // Head of the shift line holds the expectation pushed LATENCY edges ago.
  assign do_cmp   = vld_q[LATENCY-1] && ((state_q == PRIME) || (state_q == CHECK));
  assign cmp_fail = do_cmp && (bus.dut_out != exp_q[LATENCY-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.en) state_d = PRIME;
        PRIME: begin
          if (cmp_fail && STOP_ON_ERR) state_d = HALT;
          else if (vld_q[LATENCY-1])   state_d = CHECK;
        end
        CHECK: begin
          if (cmp_fail && STOP_ON_ERR)        state_d = HALT;
          else if (!bus.en && (vld_q == '0))  state_d = IDLE;
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.checking = (state_q == CHECK);
    bus.halted   = (state_q == HALT);
  end

  always_comb begin
    vld_d      = vld_q;
    exp_d      = exp_q;
    mismatch_d = 1'b0;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    pass_cnt_d = pass_cnt_q;
    last_exp_d = last_exp_q;
    last_got_d = last_got_q;
    if (bus.clear) begin
      vld_d = '0;
      for (int i = 0; i < LATENCY; i++) exp_d[i] = '0;
      err_flag_d = 1'b0;
      err_cnt_d  = '0;
      pass_cnt_d = '0;
      last_exp_d = '0;
      last_got_d = '0;
    end else if (state_q != HALT) begin
      vld_d[0] = bus.en;
      exp_d[0] = {WIDTH{&bus.stim}};
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        exp_d[i] = exp_q[i-1];
      end
      if (cmp_fail) begin
        mismatch_d = 1'b1;
        err_flag_d = 1'b1;
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
        last_exp_d = exp_q[LATENCY-1];
        last_got_d = bus.dut_out;
      end else if (do_cmp) begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) exp_q[i] <= '0;
      mismatch_q <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      pass_cnt_q <= '0;
      last_exp_q <= '0;
      last_got_q <= '0;
    end else begin
      vld_q      <= vld_d;
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      last_exp_q <= last_exp_d;
      last_got_q <= last_got_d;
    end
  end

  assign bus.mismatch   = mismatch_q;
  assign bus.err_flag   = err_flag_q;
  assign bus.err_count  = err_cnt_q;
  assign bus.pass_count = pass_cnt_q;
  assign bus.last_exp   = last_exp_q;
  assign bus.last_got   = last_got_q;
endmodule
